cu_ex_seq: RTL and testbench

//  Parametrised execute-stage sequencer for the CU: next generation of the fixed 4-phase EX controller.

---
 rtl/cu_ex_seq.sv | 158 +++++++++++++++
 tb/tb_cu_ex_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_ex_seq.sv
// Execute-stage sequencer: takes one instruction, selects operands, runs an external
// ALU through start/done with a completion timeout, and holds the result until consumed.
module cu_ex_seq #(
   parameter int XLEN    = 32,
   parameter int OPW     = 5,
   parameter int TIMEOUT = 8,
   localparam int TW     = $clog2(TIMEOUT + 1)
) (
   input  logic            soc_clk,
   input  logic            EX_reset,
   input  logic            EX_stall,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm_data,
   input  logic            use_imm,
   input  logic [OPW-1:0]  instr_op,
   input  logic [1:0]      fwd_sel,
   input  logic [XLEN-1:0] fwd_data1,
   input  logic [XLEN-1:0] fwd_data2,
   output logic            alu_start,
   output logic [XLEN-1:0] alu_dat1,
   output logic [XLEN-1:0] alu_dat2,
   output logic [OPW-1:0]  alu_op,
   input  logic            alu_done,
   input  logic [XLEN-1:0] alu_out,
   input  logic [3:0]      alu_flags,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] result_data,
   output logic            overflow_flag,
   output logic            zero_flag,
   output logic            condition_met_flag,
   output logic            error_flag,
   output logic            timeout_flag,
   output logic            busy,
   output logic [1:0]      dbg_state,
   output logic [TW-1:0]   dbg_timer
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t          state;
   logic [TW-1:0]   timer;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [XLEN-1:0] imm_q;
   logic            use_imm_q;
   logic [OPW-1:0]  op_q;
   logic            accept;

   // Handshakes: a transfer happens on the edge where valid && ready are both high;
   // valid never depends on ready, and an offered result stays stable until taken.
   assign in_ready  = !EX_reset && !EX_stall &&
                      ((state == S_IDLE) || ((state == S_HOLD) && res_ready));
   assign accept    = in_valid && in_ready;
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;
   assign dbg_timer = timer;

   always_ff @(posedge soc_clk) begin
      if (EX_reset) begin
         state              <= S_IDLE;
         timer              <= '0;
         rs1_q              <= '0;
         rs2_q              <= '0;
         imm_q              <= '0;
         use_imm_q          <= 1'b0;
         op_q               <= '0;
         alu_start          <= 1'b0;
         alu_dat1           <= '0;
         alu_dat2           <= '0;
         alu_op             <= '0;
         res_valid          <= 1'b0;
         result_data        <= '0;
         overflow_flag      <= 1'b0;
         zero_flag          <= 1'b0;
         condition_met_flag <= 1'b0;
         error_flag         <= 1'b0;
         timeout_flag       <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rs1_q     <= rs1_data;
                  rs2_q     <= rs2_data;
                  imm_q     <= imm_data;
                  use_imm_q <= use_imm;
                  op_q      <= instr_op;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!EX_stall) begin
                  alu_dat1  <= fwd_sel[0] ? fwd_data1 : rs1_q;
                  alu_dat2  <= fwd_sel[1] ? fwd_data2 : (use_imm_q ? imm_q : rs2_q);
                  alu_op    <= op_q;
                  alu_start <= 1'b1;
                  timer     <= '0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // The ALU is never stalled, so its answer is taken even while frozen.
               if (alu_done) begin
                  result_data        <= alu_out;
                  error_flag         <= alu_flags[3];
                  condition_met_flag <= alu_flags[2];
                  zero_flag          <= alu_flags[1];
                  overflow_flag      <= alu_flags[0];
                  timeout_flag       <= 1'b0;
                  res_valid          <= 1'b1;
                  state              <= S_HOLD;
               end else if (!EX_stall) begin
                  if (timer == T_LAST) begin
                     result_data        <= '0;
                     error_flag         <= 1'b1;
                     condition_met_flag <= 1'b0;
                     zero_flag          <= 1'b0;
                     overflow_flag      <= 1'b0;
                     timeout_flag       <= 1'b1;
                     res_valid          <= 1'b1;
                     state              <= S_HOLD;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (!EX_stall && res_ready) begin
                  res_valid <= 1'b0;
                  if (accept) begin
                     rs1_q     <= rs1_data;
                     rs2_q     <= rs2_data;
                     imm_q     <= imm_data;
                     use_imm_q <= use_imm;
                     op_q      <= instr_op;
                     state     <= S_ISSUE;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cu_ex_seq.sv
// Directed bench for cu_ex_seq with a registered one-cycle ALU model and a manual done override.
module tb_cu_ex_seq;

   localparam int XLEN = 32;
   localparam int OPW  = 5;
   localparam int TW   = 4;
   localparam logic [OPW-1:0] OP_ADD = 5'd0;
   localparam logic [OPW-1:0] OP_SUB = 5'd1;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_HOLD = 2'd3;

   logic            soc_clk = 1'b0;
   logic            EX_reset = 1'b1;
   logic            EX_stall = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, imm_data = '0;
   logic            use_imm = 1'b0;
   logic [OPW-1:0]  instr_op = '0;
   logic [1:0]      fwd_sel = 2'b00;
   logic [XLEN-1:0] fwd_data1 = '0, fwd_data2 = '0;
   logic            alu_start;
   logic [XLEN-1:0] alu_dat1, alu_dat2;
   logic [OPW-1:0]  alu_op;
   logic            alu_done;
   logic [XLEN-1:0] alu_out = '0;
   logic [3:0]      alu_flags = '0;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [XLEN-1:0] result_data;
   logic            overflow_flag, zero_flag, condition_met_flag, error_flag, timeout_flag;
   logic            busy;
   logic [1:0]      dbg_state;
   logic [TW-1:0]   dbg_timer;

   logic            alu_auto = 1'b1;
   logic            auto_done = 1'b0;
   logic            man_done = 1'b0;
   int              checks = 0;
   int              failures = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] exp_r;

   cu_ex_seq #(.XLEN(XLEN), .OPW(OPW), .TIMEOUT(8)) dut (
      .soc_clk(soc_clk), .EX_reset(EX_reset), .EX_stall(EX_stall),
      .in_valid(in_valid), .in_ready(in_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_data(imm_data),
      .use_imm(use_imm), .instr_op(instr_op), .fwd_sel(fwd_sel),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .alu_start(alu_start), .alu_dat1(alu_dat1), .alu_dat2(alu_dat2), .alu_op(alu_op),
      .alu_done(alu_done), .alu_out(alu_out), .alu_flags(alu_flags),
      .res_valid(res_valid), .res_ready(res_ready), .result_data(result_data),
      .overflow_flag(overflow_flag), .zero_flag(zero_flag),
      .condition_met_flag(condition_met_flag), .error_flag(error_flag),
      .timeout_flag(timeout_flag), .busy(busy),
      .dbg_state(dbg_state), .dbg_timer(dbg_timer)
   );

   // clock / reset
   always #5 soc_clk = ~soc_clk;

   function automatic logic [XLEN-1:0] model_res(input logic [OPW-1:0] op,
                                                 input logic [XLEN-1:0] a, b);
      return (op == OP_SUB) ? a - b : a + b;
   endfunction

   function automatic logic [3:0] model_flags(input logic [OPW-1:0] op,
                                              input logic [XLEN-1:0] a, b);
      logic [XLEN-1:0] r;
      logic ovf;
      r = model_res(op, a, b);
      if (op == OP_SUB) ovf = (a[XLEN-1] != b[XLEN-1]) && (r[XLEN-1] != a[XLEN-1]);
      else              ovf = (a[XLEN-1] == b[XLEN-1]) && (r[XLEN-1] != a[XLEN-1]);
      return {1'b0, (a == b), (r == '0), ovf};
   endfunction

   // Registered ALU: answers one cycle after it sees start.
   always @(posedge soc_clk) begin
      auto_done <= alu_auto && alu_start;
      if (alu_start) begin
         alu_out   <= model_res(alu_op, alu_dat1, alu_dat2);
         alu_flags <= model_flags(alu_op, alu_dat1, alu_dat2);
      end
   end
   assign alu_done = auto_done | man_done;

   // driver tasks
   task automatic tick();
      @(posedge soc_clk);
      #1;
   endtask

   task automatic offer(input logic [XLEN-1:0] r1, r2, im, input logic ui,
                        input logic [OPW-1:0] op);
      rs1_data = r1; rs2_data = r2; imm_data = im; use_imm = ui; instr_op = op;
      in_valid = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_result(input string tag);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=%0h expected=<empty queue>", tag, result_data);
      end else begin
         exp_r = exp_q.pop_front();
         chk(tag, result_data, exp_r);
      end
   endtask

   initial begin
      // reset
      tick(); tick();
      chk("rst_res_valid", res_valid, 0);
      chk("rst_alu_start", alu_start, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result_data, 0);
      chk("rst_dat1", alu_dat1, 0);
      EX_reset = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);

      // 5 + imm 7, one-cycle ALU
      offer(32'd5, 32'd99, 32'd7, 1'b1, OP_ADD);
      exp_q.push_back(32'd12);
      tick();
      in_valid = 1'b0;
      chk("t1_state_issue", dbg_state, ST_ISSUE);
      tick();
      chk("t1_start", alu_start, 1);
      chk("t1_dat1", alu_dat1, 32'd5);
      chk("t1_dat2", alu_dat2, 32'd7);
      tick();
      chk("t1_start_drop", alu_start, 0);
      chk("t1_no_valid_yet", res_valid, 0);
      tick();
      chk("t1_res_valid", res_valid, 1);
      chk_result("t1_result");
      chk("t1_zero", zero_flag, 0);
      chk("t1_timeout", timeout_flag, 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t1_released", res_valid, 0);
      chk("t1_idle", busy, 0);

      // forwarded operands -1 + 1
      offer(32'd3, 32'd4, 32'd0, 1'b0, OP_ADD);
      fwd_sel = 2'b11; fwd_data1 = 32'hFFFF_FFFF; fwd_data2 = 32'd1;
      exp_q.push_back(32'd0);
      tick();
      in_valid = 1'b0;
      tick();
      chk("t2_dat1_fwd", alu_dat1, 32'hFFFF_FFFF);
      chk("t2_dat2_fwd", alu_dat2, 32'd1);
      fwd_sel = 2'b00;
      tick(); tick();
      chk("t2_res_valid", res_valid, 1);
      chk_result("t2_result");
      chk("t2_zero", zero_flag, 1);
      chk("t2_overflow", overflow_flag, 0);

      // consumer holds off for 5 cycles, then takes result while a new op is offered
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_valid", res_valid, 1);
         chk("t4_hold_zero", zero_flag, 1);
         chk("t4_hold_ready", in_ready, 0);
      end
      res_ready = 1'b1;
      offer(32'd10, 32'd3, 32'd0, 1'b0, OP_SUB);
      exp_q.push_back(32'd7);
      #1;
      chk("t4_in_ready", in_ready, 1);
      chk("t4_result_stable", result_data, 32'd0);
      tick();
      in_valid = 1'b0; res_ready = 1'b0;
      chk("t4_b2b_issue", dbg_state, ST_ISSUE);
      chk("t4_valid_drop", res_valid, 0);
      tick();
      chk("t4_dat1", alu_dat1, 32'd10);
      chk("t4_op", alu_op, OP_SUB);
      tick(); tick();
      chk("t4_res_valid", res_valid, 1);
      chk_result("t4_result");
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t4_idle", dbg_state, ST_IDLE);

      // ALU never answers: timeout after 8 WAIT cycles
      alu_auto = 1'b0;
      offer(32'd1, 32'd0, 32'd1, 1'b1, OP_ADD);
      exp_q.push_back(32'd0);
      tick();
      in_valid = 1'b0;
      tick();
      chk("t3_wait", dbg_state, ST_WAIT);
      for (int i = 0; i < 7; i++) tick();
      chk("t3_not_yet", res_valid, 0);
      tick();
      chk("t3_res_valid", res_valid, 1);
      chk_result("t3_result");
      chk("t3_error", error_flag, 1);
      chk("t3_timeout", timeout_flag, 1);
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("t3_late_done_result", result_data, 0);
      chk("t3_late_done_timeout", timeout_flag, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("t3_idle_done_ignored", res_valid, 0);
      chk("t3_idle", dbg_state, ST_IDLE);

      // stall in ISSUE, then in WAIT while done pulses
      offer(32'd2, 32'd0, 32'd3, 1'b1, OP_ADD);
      exp_q.push_back(32'd5);
      tick();
      in_valid = 1'b0;
      EX_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_start", alu_start, 0);
         chk("t5_frozen_issue", dbg_state, ST_ISSUE);
      end
      EX_stall = 1'b0;
      tick();
      chk("t5_start", alu_start, 1);
      EX_stall = 1'b1;
      tick(); tick();
      chk("t5_timer_frozen", dbg_timer, 0);
      chk("t5_still_wait", dbg_state, ST_WAIT);
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("t5_captured", res_valid, 1);
      chk_result("t5_result");
      res_ready = 1'b1;
      #1;
      chk("t5_stall_no_ready", in_ready, 0);
      tick();
      chk("t5_stall_hold", dbg_state, ST_HOLD);
      EX_stall = 1'b0;
      tick();
      res_ready = 1'b0;
      chk("t5_idle", dbg_state, ST_IDLE);

      // reset mid-WAIT, then a stray done
      offer(32'd9, 32'd0, 32'd4, 1'b1, OP_ADD);
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("t6_in_wait", dbg_state, ST_WAIT);
      EX_reset = 1'b1;
      tick();
      chk("t6_rst_idle", dbg_state, ST_IDLE);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_dat1", alu_dat1, 0);
      chk("t6_rst_in_ready", in_ready, 0);
      EX_reset = 1'b0;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("t6_no_res_valid", res_valid, 0);
      chk("t6_result_zero", result_data, 0);
      chk("t6_still_idle", busy, 0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
